// File: rtl/rank_gen_param.sv
// rtl/rank_gen_param.sv - sequential stable ranking engine for N unsigned channel counts
module rank_gen_param #(
    parameter int N  = 6,
    parameter int W  = 8,
    parameter int RW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            desc,
    input  logic [N*W-1:0]  cnt_flat,
    output logic            busy,
    output logic            done,
    output logic            rank_valid,
    output logic [N*RW-1:0] rank_flat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]  snap [N];
    logic [RW-1:0] rank [N];
    logic [RW-1:0] ptr;
    logic          mode;
    logic          accept;
    logic          last;
    logic [W-1:0]  sel;
    logic [N-1:0]  bump;

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and start acceptance (start only matters in IDLE/DONE).
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Final RUN cycle is the one that visits the last channel.
    always_comb begin
        last = (ptr == RW'(N - 1));
    end

    // Select the snapshot of the channel currently being compared against.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr == RW'(i)) begin
                sel = snap[i];
            end
        end
    end

    // Per-channel increment: selected channel is strictly better, or equal with lower index.
    always_comb begin
        bump = '0;
        for (int i = 0; i < N; i++) begin
            if (mode) begin
                bump[i] = (snap[i] < sel) || ((snap[i] == sel) && (ptr < RW'(i)));
            end else begin
                bump[i] = (snap[i] > sel) || ((snap[i] == sel) && (ptr < RW'(i)));
            end
        end
    end

    // Snapshot on acceptance, accumulate ranks during RUN, flag results on entry to DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr        <= '0;
            mode       <= 1'b0;
            rank_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                snap[i] <= '0;
                rank[i] <= '0;
            end
        end else if (accept) begin
            ptr        <= '0;
            mode       <= desc;
            rank_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                snap[i] <= cnt_flat[i*W +: W];
                rank[i] <= '0;
            end
        end else if (state == S_RUN) begin
            ptr <= ptr + RW'(1);
            for (int i = 0; i < N; i++) begin
                if (bump[i]) begin
                    rank[i] <= rank[i] + RW'(1);
                end
            end
            if (last) begin
                rank_valid <= 1'b1;
            end
        end
    end

    // Flatten registered ranks onto the output bus.
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_flat
            assign rank_flat[g*RW +: RW] = rank[g];
        end
    endgenerate

endmodule

// File: tb/tb_rank_gen_param.sv
// tb/tb_rank_gen_param.sv - directed self-checking bench for rank_gen_param
module tb_rank_gen_param;

    logic        clk;
    logic        reset;
    logic        start;
    logic        desc;
    logic [47:0] cnt_flat;
    logic        busy;
    logic        done;
    logic        rank_valid;
    logic [17:0] rank_flat;

    int tests;
    int fails;

    rank_gen_param #(.N(6), .W(8), .RW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .desc       (desc),
        .cnt_flat   (cnt_flat),
        .busy       (busy),
        .done       (done),
        .rank_valid (rank_valid),
        .rank_flat  (rank_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] cv(input int c0, c1, c2, c3, c4, c5);
        logic [7:0] a0, a1, a2, a3, a4, a5;
        a0 = c0[7:0]; a1 = c1[7:0]; a2 = c2[7:0];
        a3 = c3[7:0]; a4 = c4[7:0]; a5 = c5[7:0];
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [17:0] rk(input int r0, r1, r2, r3, r4, r5);
        logic [2:0] a0, a1, a2, a3, a4, a5;
        a0 = r0[2:0]; a1 = r1[2:0]; a2 = r2[2:0];
        a3 = r3[2:0]; a4 = r4[2:0]; a5 = r5[2:0];
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full run with a start pulse; checks latency, busy length, ranks and hold in IDLE.
    task automatic run_check(input string name, input logic d, input logic [47:0] c,
                             input logic [17:0] exp);
        int cyc;
        int busy_cnt;
        bit seen;
        desc     = d;
        cnt_flat = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cnt_flat = ~c;
        desc     = ~d;
        cyc = 1; busy_cnt = 0; seen = 0;
        while (cyc <= 20) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
            tick();
            cyc++;
        end
        tests++;
        if (!seen || cyc != 7) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d), expected 7", name, cyc, seen);
        end
        tests++;
        if (busy_cnt != 6) begin
            fails++;
            $display("FAIL %s busy_len: got %0d, expected 6", name, busy_cnt);
        end
        tests++;
        if (rank_flat !== exp || rank_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s ranks: got %h rv=%b, expected %h rv=1", name, rank_flat, rank_valid, exp);
        end
        tick();
        tick();
        tests++;
        if (rank_flat !== exp || rank_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_hold: got rank=%h rv=%b done=%b busy=%b, expected rank=%h rv=1 done=0 busy=0",
                     name, rank_flat, rank_valid, done, busy, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; desc = 1'b0; cnt_flat = '0;
        tick();
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || rank_valid !== 1'b0 || rank_flat !== 18'd0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b rv=%b rank=%h, expected all 0",
                     busy, done, rank_valid, rank_flat);
        end
        reset = 1'b1;
        tick();
        desc = 1'b1; cnt_flat = cv(10, 50, 30, 20, 60, 40); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_midrun_busy: got %b, expected 1", busy);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || rank_valid !== 1'b0 || rank_flat !== 18'd0) begin
            fails++;
            $display("FAIL reset_abort: got busy=%b done=%b rv=%b rank=%h, expected all 0",
                     busy, done, rank_valid, rank_flat);
        end
        tick();
        reset = 1'b1;
        begin
            int dn;
            dn = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (done || busy) dn++;
            end
            tests++;
            if (dn != 0) begin
                fails++;
                $display("FAIL reset_stays_idle: got %0d active cycles, expected 0", dn);
            end
        end
    endtask

    task automatic test_desc;
        run_check("desc", 1'b1, cv(10, 50, 30, 20, 60, 40), rk(5, 1, 3, 4, 0, 2));
    endtask

    task automatic test_asc;
        run_check("asc", 1'b0, cv(10, 50, 30, 20, 60, 40), rk(0, 4, 2, 1, 5, 3));
    endtask

    task automatic test_ties;
        run_check("ties_all", 1'b1, cv(7, 7, 7, 7, 7, 7), rk(0, 1, 2, 3, 4, 5));
        run_check("ties_mix", 1'b1, cv(0, 255, 0, 255, 1, 1), rk(4, 0, 5, 1, 2, 3));
        run_check("ties_asc", 1'b0, cv(0, 255, 0, 255, 1, 1), rk(0, 4, 1, 5, 2, 3));
    endtask

    task automatic test_ignore_start;
        int dn;
        logic [17:0] got;
        desc = 1'b1; cnt_flat = cv(10, 50, 30, 20, 60, 40); start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0; got = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 2) begin
                cnt_flat = cv(60, 50, 40, 30, 20, 10);
                desc     = 1'b0;
                start    = 1'b1;
            end
            if (cyc == 3) start = 1'b0;
            if (done) begin
                dn++;
                got = rank_flat;
            end
            tick();
        end
        tests++;
        if (dn != 1) begin
            fails++;
            $display("FAIL ignore_done_count: got %0d, expected 1", dn);
        end
        tests++;
        if (got !== rk(5, 1, 3, 4, 0, 2)) begin
            fails++;
            $display("FAIL ignore_ranks: got %h, expected %h", got, rk(5, 1, 3, 4, 0, 2));
        end
    endtask

    task automatic test_back_to_back;
        int dn;
        int bad;
        desc = 1'b0; cnt_flat = cv(3, 1, 4, 1, 5, 9); start = 1'b1;
        tick();
        dn = 0; bad = 0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            if (done) begin
                dn++;
                if (cyc % 7 != 0) bad++;
                if (rank_flat !== rk(2, 0, 3, 1, 4, 5)) bad++;
                if (cyc == 21) start = 1'b0;
            end
            if (cyc == 8 && (busy !== 1'b1 || rank_valid !== 1'b0)) begin
                bad++;
                $display("FAIL b2b_restart: got busy=%b rv=%b, expected busy=1 rv=0", busy, rank_valid);
            end
            tick();
        end
        tests++;
        if (dn != 3 || bad != 0) begin
            fails++;
            $display("FAIL b2b: got %0d dones with %0d errors, expected 3 dones with 0 errors", dn, bad);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || rank_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stop: got busy=%b rv=%b, expected busy=0 rv=1", busy, rank_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0; start = 1'b0; desc = 1'b0; cnt_flat = '0;
        @(negedge clk);
        test_reset();
        test_desc();
        test_asc();
        test_ties();
        test_ignore_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
